bist_march_engine: RTL and testbench

- Parametrised next-generation memory BIST engine for single-port synchronous SRAM.
- Integrates the state machine, up/down address counter, data background generator and read-data comparator.
- Supports run-time selection of March X (6N) or March C- (10N).
- Sits between the test-access logic (start/mode/result) and the SRAM port mux.

---
 rtl/bist_march_engine.sv | 180 ++++++++++++++++++
 tb/tb_bist_march_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bist_march_engine.sv
// March X / March C- BIST engine for a single-port synchronous SRAM.
// Define BIST_CHECKERBOARD_EN to rerun the selected algorithm with a checkerboard background.
module bist_march_engine #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              bist_clk,
    input  logic              bist_rst,
    input  logic              bist_start,
    input  logic              bist_mode,
    input  logic [DATA_W-1:0] bist_dout,
    output logic              bist_cs,
    output logic              bist_we,
    output logic [ADDR_W-1:0] bist_addr,
    output logic [DATA_W-1:0] bist_din,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_bits
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e            state_q;
    logic              mode_q;
    logic [2:0]        elem_q;
    logic [ADDR_W-1:0] addr_q;
    logic              op_q;
    logic              pass_q;
    logic              drain_q;

    // Read-compare pipeline: stage 1 rides with the command, stage 2 with the SRAM access.
    logic [1:0]        rd_vld_q;
    logic [DATA_W-1:0] exp1_q, exp2_q;
    logic [ADDR_W-1:0] paddr1_q, paddr2_q;
    logic [2:0]        pelem1_q, pelem2_q;

    logic [2:0]        last_elem, elem_nxt, elem_tag;
    logic              two_op, is_down, nxt_down, is_read, inv, addr_end, last_cmd;
    logic [DATA_W-1:0] bg, cmd_data;

    always_comb begin
        last_elem = mode_q ? 3'd5 : 3'd3;
        elem_nxt  = elem_q + 3'd1;
        two_op    = (elem_q != 3'd0) && (elem_q != last_elem);
        is_down   = mode_q ? (elem_q >= 3'd3) : (elem_q >= 3'd2);
        nxt_down  = mode_q ? (elem_nxt >= 3'd3) : (elem_nxt >= 3'd2);
        is_read   = (elem_q != 3'd0) && !op_q;
        // Odd elements read D and write ~D; even elements read ~D and write D (e0 writes D).
        inv       = is_read ? ~elem_q[0] : elem_q[0];
        addr_end  = is_down ? (addr_q == '0) : (addr_q == '1);
`ifdef BIST_CHECKERBOARD_EN
        bg        = pass_q ? (addr_q[0] ? ~{DATA_W/2{2'b01}} : {DATA_W/2{2'b01}}) : '0;
        elem_tag  = (pass_q && !mode_q) ? elem_q + 3'd4 : elem_q;
        last_cmd  = addr_end && (op_q || !two_op) && (elem_q == last_elem) && pass_q;
`else
        bg        = '0;
        elem_tag  = elem_q;
        last_cmd  = addr_end && (op_q || !two_op) && (elem_q == last_elem);
`endif
        cmd_data  = inv ? ~bg : bg;
    end

    always_ff @(posedge bist_clk) begin
        if (bist_rst) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            elem_q    <= '0;
            addr_q    <= '0;
            op_q      <= 1'b0;
            pass_q    <= 1'b0;
            drain_q   <= 1'b0;
            rd_vld_q  <= '0;
            exp1_q    <= '0;
            exp2_q    <= '0;
            paddr1_q  <= '0;
            paddr2_q  <= '0;
            pelem1_q  <= '0;
            pelem2_q  <= '0;
            bist_cs   <= 1'b0;
            bist_we   <= 1'b0;
            bist_addr <= '0;
            bist_din  <= '0;
            bist_busy <= 1'b0;
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_bits <= '0;
        end else begin
            rd_vld_q <= {rd_vld_q[0], 1'b0};
            exp2_q   <= exp1_q;
            paddr2_q <= paddr1_q;
            pelem2_q <= pelem1_q;

            if (rd_vld_q[1] && (bist_dout != exp2_q)) begin
                bist_fail <= 1'b1;
                if (!bist_fail) begin
                    fail_addr <= paddr2_q;
                    fail_elem <= pelem2_q;
                    fail_bits <= bist_dout ^ exp2_q;
                end
            end

            case (state_q)
                IDLE: begin
                    bist_cs   <= 1'b0;
                    bist_we   <= 1'b0;
                    bist_addr <= '0;
                    bist_din  <= '0;
                    if (bist_start) begin
                        state_q   <= RUN;
                        mode_q    <= bist_mode;
                        elem_q    <= '0;
                        addr_q    <= '0;
                        op_q      <= 1'b0;
                        pass_q    <= 1'b0;
                        bist_busy <= 1'b1;
                        bist_fail <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                        fail_bits <= '0;
                    end
                end
                RUN: begin
                    bist_cs   <= 1'b1;
                    bist_we   <= !is_read;
                    bist_addr <= addr_q;
                    bist_din  <= is_read ? '0 : cmd_data;
                    rd_vld_q  <= {rd_vld_q[0], is_read};
                    exp1_q    <= cmd_data;
                    paddr1_q  <= addr_q;
                    pelem1_q  <= elem_tag;
                    if (two_op && !op_q) begin
                        op_q <= 1'b1;
                    end else begin
                        op_q <= 1'b0;
                        if (!addr_end) begin
                            addr_q <= is_down ? addr_q - 1'b1 : addr_q + 1'b1;
                        end else if (elem_q != last_elem) begin
                            // Element boundary: reload the start address of the next element.
                            elem_q <= elem_nxt;
                            addr_q <= nxt_down ? '1 : '0;
                        end else begin
                            pass_q <= 1'b1;
                            elem_q <= '0;
                            addr_q <= '0;
                        end
                    end
                    if (last_cmd) begin
                        state_q <= DRAIN;
                        drain_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    bist_cs   <= 1'b0;
                    bist_we   <= 1'b0;
                    bist_addr <= '0;
                    bist_din  <= '0;
                    drain_q   <= 1'b1;
                    if (drain_q) begin
                        state_q   <= DONE;
                        bist_busy <= 1'b0;
                        bist_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bist_start) begin
                        state_q   <= IDLE;
                        bist_done <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_march_engine.sv
// Randomized bench for bist_march_engine: march command stream, timing and fault reporting
// checked against a string-table march model driving a behavioural faulty SRAM.
module tb_bist_march_engine;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic          bist_clk = 1'b0;
    logic          bist_rst, bist_start, bist_mode;
    logic [DW-1:0] bist_dout;
    logic          bist_cs, bist_we, bist_busy, bist_done, bist_fail;
    logic [AW-1:0] bist_addr, fail_addr;
    logic [DW-1:0] bist_din, fail_bits;
    logic [2:0]    fail_elem;

    bist_march_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .bist_clk(bist_clk), .bist_rst(bist_rst), .bist_start(bist_start), .bist_mode(bist_mode),
        .bist_dout(bist_dout), .bist_cs(bist_cs), .bist_we(bist_we), .bist_addr(bist_addr),
        .bist_din(bist_din), .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_bits(fail_bits)
    );

    always #5 bist_clk = ~bist_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit       we;
        bit [3:0] addr;
        bit [7:0] data;
        bit [2:0] elem;
    } cmd_t;

    cmd_t  cmds[$];
    string mx[4] = '{"Uw0", "Ur0w1", "Dr1w0", "Dr0"};
    string mc[6] = '{"Uw0", "Ur0w1", "Ur1w0", "Dr0w1", "Dr1w0", "Dr0"};

    // Fault: 0 none, 1 stuck-at (fmask bits read as fval), 2 fmask bits cannot fall 1->0
    int       fk, fa;
    bit [7:0] fmask, fval;
    bit [7:0] mem[N];
    bit [7:0] mm[N];

    function automatic bit [7:0] bg(int a, int p);
        if (p == 0) return 8'h00;
        return ((a % 2) == 0) ? 8'h55 : 8'hAA;
    endfunction

    function automatic bit [7:0] f_rd(int a, bit [7:0] v);
        if (fk == 1 && a == fa) return (v & ~fmask) | (fval & fmask);
        return v;
    endfunction

    function automatic bit [7:0] f_wr(int a, bit [7:0] old, bit [7:0] nw);
        if (fk == 2 && a == fa) return nw | (old & fmask);
        return nw;
    endfunction

    task automatic build(input bit m);
        int    npass;
        string s;
        cmd_t  c;
        cmds.delete();
        npass = 1;
`ifdef BIST_CHECKERBOARD_EN
        npass = 2;
`endif
        for (int p = 0; p < npass; p++)
            for (int e = 0; e < (m ? 6 : 4); e++) begin
                s = m ? mc[e] : mx[e];
                for (int i = 0; i < N; i++) begin
                    int a;
                    a = (s[0] == "D") ? N - 1 - i : i;
                    for (int j = 1; j < s.len(); j += 2) begin
                        c.we   = (s[j] == "w");
                        c.addr = 4'(a);
                        c.data = (s[j+1] == "1") ? ~bg(a, p) : bg(a, p);
                        c.elem = (p == 1 && !m) ? 3'(e + 4) : 3'(e);
                        cmds.push_back(c);
                    end
                end
            end
    endtask

    // One clock: SRAM samples the registered command, read data valid one cycle later.
    task automatic tick();
        logic          c, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        c = bist_cs; w = bist_we; a = bist_addr; d = bist_din;
        @(posedge bist_clk);
        #1;
        if (c === 1'b1 && w === 1'b1) mem[a] = f_wr(int'(a), mem[a], d);
        else if (c === 1'b1) bist_dout = f_rd(int'(a), mem[a]);
        @(negedge bist_clk);
    endtask

    function automatic logic [31:0] all_outs();
        return {bist_cs, bist_we, bist_addr, bist_din, bist_busy, bist_done,
                bist_fail, fail_addr, fail_elem, fail_bits};
    endfunction

    task automatic run(input bit m, input int kind, input int fa_i, input bit [7:0] mask,
                       input bit [7:0] val, input bit zero_init, input int hold,
                       input bit drop, input int rst_at);
        int       L;
        bit       ef;
        bit [3:0] ea;
        bit [2:0] eel;
        bit [7:0] eb, r;
        build(m);
        L = cmds.size();
        fk = kind; fa = fa_i; fmask = mask; fval = val;
        for (int a = 0; a < N; a++) begin
            mem[a] = zero_init ? 8'h00 : 8'($urandom);
            mm[a]  = mem[a];
        end
        ef = 0; ea = 0; eel = 0; eb = 0;
        foreach (cmds[k]) begin
            if (cmds[k].we) mm[cmds[k].addr] = f_wr(int'(cmds[k].addr), mm[cmds[k].addr], cmds[k].data);
            else begin
                r = f_rd(int'(cmds[k].addr), mm[cmds[k].addr]);
                if (r != cmds[k].data && !ef) begin
                    ef = 1; ea = cmds[k].addr; eel = cmds[k].elem; eb = r ^ cmds[k].data;
                end
            end
        end

        bist_start = 1'b1;
        bist_mode  = m;
        tick();
        chk("start", 32'({bist_busy, bist_done, bist_cs}), 32'(3'b100));
        bist_mode = 1'($urandom);
        for (int t = 1; t <= L + 2; t++) begin
            tick();
            if (t <= L) begin
                chk("cmd", 32'({bist_cs, bist_we, bist_addr, bist_din}),
                    32'({1'b1, cmds[t-1].we, cmds[t-1].addr, cmds[t-1].we ? cmds[t-1].data : 8'h00}));
                chk("run", 32'({bist_busy, bist_done}), 32'(2'b10));
            end else if (t == L + 1) begin
                chk("drain", 32'({bist_cs, bist_busy, bist_done}), 32'(3'b010));
            end else begin
                chk("done", 32'({bist_cs, bist_busy, bist_done}), 32'(3'b001));
                chk("result", 32'({bist_fail, fail_addr, fail_elem, fail_bits}), 32'({ef, ea, eel, eb}));
            end
            bist_mode = 1'($urandom);
            if (drop && t == L / 2) bist_start = 1'b0;
            if (rst_at != 0 && t == rst_at - 1) begin
                bist_rst = 1'b1;
                tick();
                chk("abort", all_outs(), 32'h0);
                bist_rst   = 1'b0;
                bist_start = 1'b0;
                tick();
                return;
            end
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold", 32'({bist_busy, bist_done}), 32'(2'b01));
        end
        bist_start = 1'b0;
        tick();
        chk("idle", 32'({bist_busy, bist_done, bist_cs}), 32'(3'b000));
        chk("kept", 32'({bist_fail, fail_addr, fail_elem, fail_bits}), 32'({ef, ea, eel, eb}));
    endtask

    initial begin
        bist_rst = 1'b1; bist_start = 1'b0; bist_mode = 1'b0; bist_dout = '0;
        fk = 0; fa = 0; fmask = 0; fval = 0;
        tick(); tick();
        chk("reset", all_outs(), 32'h0);
        bist_rst = 1'b0;
        tick(); tick(); tick();
        chk("idle0", all_outs(), 32'h0);
        bist_rst = 1'b1; bist_start = 1'b1;
        tick();
        chk("rst_wins", all_outs(), 32'h0);
        bist_rst = 1'b0; bist_start = 1'b0;
        tick();
        chk("still_idle", all_outs(), 32'h0);

        run(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        run(1, 0, 0, 8'h00, 8'h00, 0, 3, 0, 0);
        run(0, 1, 5, 8'h08, 8'h08, 0, 1, 0, 0);
        run(1, 2, 9, 8'hFF, 8'h00, 1, 0, 0, 0);
        run(0, 1, 5, 8'h08, 8'h08, 0, 0, 0, 40);
        run(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        run(1, 1, int'($urandom_range(0, N - 1)), 8'h81, 8'h01, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            run(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, N - 1)),
                8'(1 << $urandom_range(0, 7)) | 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
